// File: rtl/buf_1p_64x64_sf_ctrl_pkg.sv
// Shared constants and state encoding for the
// store-and-forward block buffer controller.
package buf_1p_64x64_sf_ctrl_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int BUF_DEPTH   = 64;
  localparam int BUF_AW      = 6;

  typedef enum logic [1:0] {
    SF_IDLE  = 2'd0,
    SF_FILL  = 2'd1,
    SF_DRAIN = 2'd2
  } sf_state_e;

  // Transposed order walks columns of the 8x8 block
  function automatic logic [BUF_AW-1:0] rd_addr(
    input logic [BUF_AW-1:0] cnt,
    input logic              tr
  );
    return tr ? {cnt[2:0], cnt[5:3]} : cnt;
  endfunction

endpackage

// File: rtl/buf_ram_1p_64x64.sv
// Single-port 64 x 64-bit buffer RAM,
// synchronous read with one cycle of latency.
module buf_ram_1p_64x64 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [5:0]        addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem [64];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= data_i;
      else    data_o    <= mem[addr];
    end
  end

endmodule

// File: rtl/sf_fifo2.sv
// Two-entry output skid FIFO carrying a word
// and its last tag.
module sf_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [1:0]        cnt_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic              l0_q, l0_d, l1_q, l1_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_i) begin
      if (wr_q) begin
        d1_d = push_data_i;
        l1_d = push_last_i;
      end else begin
        d0_d = push_data_i;
        l0_d = push_last_i;
      end
      wr_d = ~wr_q;
    end
    if (pop_i) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push_i}
                  - {1'b0, pop_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign data_o = rd_q ? d1_q : d0_q;
  assign last_o = rd_q ? l1_q : l0_q;

endmodule

// File: rtl/buf_1p_64x64_sf_ctrl.sv
// Store-and-forward controller: fills 64 words into
// a single-port RAM, then drains linear or transposed.
module buf_1p_64x64_sf_ctrl
  import buf_1p_64x64_sf_ctrl_pkg::*;
#(
  parameter int DATA_W     = PIXEL_WIDTH * 8,
  parameter int DEPTH_LOG2 = BUF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  sf_state_e             state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DEPTH_LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;

  logic                  ram_ce, ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;
  logic [1:0]            fifo_cnt;
  logic                  fifo_last;
  logic                  pop;
  logic [2:0]            occ;

  assign out_valid_o = (fifo_cnt != 2'd0);
  assign out_last_o  = fifo_last;
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = (state_q == SF_FILL);
  assign busy_o      = (state_q != SF_IDLE);

  // Credit the same-cycle pop so reads sustain 1/cycle
  assign occ = {1'b0, fifo_cnt} + {2'b0, infl_q}
             - {2'b0, pop};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    done_o      = 1'b0;
    unique case (state_q)
      SF_IDLE: begin
        if (start_i) begin
          state_d  = SF_FILL;
          mode_d   = mode_i;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      SF_FILL: begin
        if (in_valid_i) begin
          ram_ce   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_cnt_q;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (&wr_cnt_q) state_d = SF_DRAIN;
        end
      end
      SF_DRAIN: begin
        if (!rd_cnt_q[DEPTH_LOG2] && occ < 3'd2) begin
          ram_ce      = 1'b1;
          ram_addr    = rd_addr(rd_cnt_q[DEPTH_LOG2-1:0],
                                mode_q);
          rd_cnt_d    = rd_cnt_q + 1'b1;
          infl_d      = 1'b1;
          infl_last_d = &rd_cnt_q[DEPTH_LOG2-1:0];
        end
        if (pop && fifo_last) begin
          state_d = SF_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = SF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SF_IDLE;
      mode_q      <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  buf_ram_1p_64x64 #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .ce     (ram_ce),
    .we     (ram_we),
    .addr   (ram_addr),
    .data_i (in_data_i),
    .data_o (ram_rdata)
  );

  sf_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (infl_q),
    .push_data_i (ram_rdata),
    .push_last_i (infl_last_q),
    .pop_i       (pop),
    .cnt_o       (fifo_cnt),
    .data_o      (out_data_o),
    .last_o      (fifo_last)
  );

endmodule

// File: tb/tb_buf_1p_64x64_sf_ctrl.sv
// Scoreboard bench for the store-and-forward
// block buffer controller.
module tb_buf_1p_64x64_sf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [63:0] out_data_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int npop   = 0;
  logic [63:0] sb[$];

  logic [63:0] held;
  bit          hold_v = 0;

  always #5 clk = ~clk;

  buf_1p_64x64_sf_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Output-side scoreboard and stall-stability monitor
  always @(negedge clk) begin
    logic [63:0] e;
    bit el;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== held) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%0d need valid=1 data=%0d",
                   out_valid_o, out_data_o, held);
        end
      end
      hold_v = out_valid_o && !out_ready_i;
      held   = out_data_o;
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0d, none expected", out_data_o);
        end else begin
          e  = sb.pop_front();
          el = (sb.size() == 0);
          if (out_data_o !== e || out_last_o !== el) begin
            errors++;
            $display("FAIL out_word: got %0d last=%b need %0d last=%b",
                     out_data_o, out_last_o, e, el);
          end
        end
        npop++;
      end
    end
  end

  function automatic logic [63:0] exp_word(int base, bit tr, int i);
    return 64'(tr ? base + (i % 8) * 8 + i / 8 : base + i);
  endfunction

  task automatic push_exp(int base, bit tr);
    for (int i = 0; i < 64; i++) sb.push_back(exp_word(base, tr, i));
  endtask

  task automatic start_job(bit m);
    @(posedge clk); #1;
    start_i = 1'b1;
    mode_i  = m;
    @(posedge clk); #1;
    start_i = 1'b0;
    mode_i  = 1'b0;
  endtask

  task automatic fill(int base, bit bubbles, bit ign);
    int k = 0;
    int cyc = 0;
    while (k < 64 && cyc < 2000) begin
      in_valid_i = !bubbles || (cyc % 2 == 0);
      in_data_i  = 64'(base + k);
      start_i    = ign && (k == 10);
      mode_i     = ign && (k == 10);
      @(negedge clk);
      if (in_valid_i && in_ready_o) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    mode_i     = 1'b0;
    checks++;
    if (k != 64) begin
      errors++;
      $display("FAIL fill_count: accepted %0d need 64", k);
    end
  endtask

  task automatic drain(int pct, int stop_after,
                       output int done_cyc, output int first_v);
    int cyc = 0;
    int p0 = npop;
    done_cyc = -1;
    first_v  = -1;
    while (cyc < 3000) begin
      out_ready_i = ($urandom_range(0, 99) < pct);
      @(negedge clk); #1;
      if (first_v < 0 && out_valid_o) first_v = cyc;
      if (stop_after > 0 && npop - p0 >= stop_after) break;
      if (done_o) begin
        done_cyc = cyc;
        checks++;
        if (!(out_valid_o && out_ready_i && out_last_o)) begin
          errors++;
          $display("FAIL done_hs: v=%b r=%b last=%b need 1 1 1",
                   out_valid_o, out_ready_i, out_last_o);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL after_done: busy=%b done=%b need 0 0", busy_o, done_o);
        end
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs: rdy=%b v=%b d=%0d l=%b busy=%b done=%b need all 0",
               in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b need 0 0", busy_o, in_ready_o);
    end
  endtask

  task automatic test_linear;
    int dc, fv;
    push_exp(0, 0);
    start_job(0);
    checks++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_entry: busy=%b rdy=%b need 1 1", busy_o, in_ready_o);
    end
    fill(0, 0, 0);
    drain(100, 0, dc, fv);
    checks++;
    if (fv != 2) begin
      errors++;
      $display("FAIL lin_first_valid: cycle %0d need 2", fv);
    end
    checks++;
    if (dc != 65) begin
      errors++;
      $display("FAIL lin_done_cycle: cycle %0d need 65", dc);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL lin_left: %0d words left need 0", sb.size());
    end
  endtask

  task automatic test_transposed;
    int dc, fv;
    push_exp(0, 1);
    start_job(1);
    fill(0, 0, 0);
    drain(100, 0, dc, fv);
    checks++;
    if (dc != 65 || sb.size() != 0) begin
      errors++;
      $display("FAIL tr_done: cycle %0d left %0d need 65 0", dc, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int dc, fv;
    push_exp(1000, 0);
    start_job(0);
    fill(1000, 0, 0);
    drain(30, 0, dc, fv);
    checks++;
    if (dc < 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_done: cycle %0d left %0d need done, 0", dc, sb.size());
    end
  endtask

  task automatic test_bubbles;
    int dc, fv;
    push_exp(500, 1);
    start_job(1);
    fill(500, 1, 0);
    in_valid_i = 1'b1;
    in_data_i  = 64'hdead;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL extra_word: in_ready=%b need 0", in_ready_o);
    end
    @(posedge clk); #1;
    drain(100, 0, dc, fv);
    in_valid_i = 1'b0;
    checks++;
    if (dc != 64 || sb.size() != 0) begin
      errors++;
      $display("FAIL bub_done: cycle %0d left %0d need 64 0", dc, sb.size());
    end
  endtask

  task automatic test_reset_mid_drain;
    int dc, fv;
    push_exp(200, 0);
    start_job(0);
    fill(200, 0, 0);
    drain(100, 20, dc, fv);
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b v=%b d=%0d l=%b busy=%b done=%b need all 0",
               in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o);
    end
    checks++;
    if (npop != 20 + 64 * 4) begin
      errors++;
      $display("FAIL pops_before_reset: %0d need %0d", npop, 20 + 64 * 4);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(100, 0);
    start_job(0);
    fill(100, 0, 0);
    drain(100, 0, dc, fv);
    checks++;
    if (dc != 65 || sb.size() != 0) begin
      errors++;
      $display("FAIL refill_done: cycle %0d left %0d need 65 0", dc, sb.size());
    end
  endtask

  task automatic test_ignored_start;
    int dc, fv;
    push_exp(300, 0);
    start_job(0);
    fill(300, 0, 1);
    drain(100, 0, dc, fv);
    checks++;
    if (dc != 65 || sb.size() != 0) begin
      errors++;
      $display("FAIL ign_done: cycle %0d left %0d need 65 0", dc, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_linear;
    test_transposed;
    test_backpressure;
    test_bubbles;
    test_reset_mid_drain;
    test_ignored_start;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
